lcd_write_engine: RTL and testbench
===================================

# lcd_write_engine

Parametrised successor to the single-byte LCD write path. Accepts command or data bytes over a valid/ready handshake and drives an HD44780-compatible bus (RS, RW, E, DB7..DB0) with configurable setup, enable-pulse, hold and execution-wait timing. Supports 8-bit and 4-bit bus modes, and applies the long wait automatically after clear and home commands. Sits between the button/debounce front end and the LCD pins, replacing direct pin driving.

## Interface
Parameters:
- SETUP_CYC, 2: cycles RS/data are stable before E rises (≥1).
- E_CYC, 12: cycles E is high (≥1).
- HOLD_CYC, 1: cycles RS/data are held after E falls (≥1).
- EXEC_CYC, 1850: post-transfer wait for normal instructions and data (≥1).
- LONG_CYC, 76000: post-transfer wait for clear/home (≥1).
- BUS_4BIT, 0: 1 selects 4-bit mode, high nibble first.

Ports:
- clk  in  1  system clock (50 MHz nominal).
- reset_n  in  1  reset; one clock; asynchronous, active-low.
- wr_valid  in  1  request present.
- wr_ready  out  1  engine idle and able to accept.
- wr_rs  in  1  0 = instruction, 1 = data.
- wr_data  in  8  byte to write.
- busy  out  1  transfer or execution wait in progress.
- done  out  1  one-cycle pulse when a transfer's wait completes.
- RW_lcd  out  1  always 0 (write-only).
- RS_lcd  out  1  registered RS.
- E_lcd  out  1  registered enable strobe.
- data_lcd  out  8  registered bus; in 4-bit mode nibble on [7:4], [3:0] driven 0.

## Operation
- States: IDLE, SETUP, E_HIGH, HOLD, WAIT_EXEC.
- IDLE: wr_ready=1. On wr_valid&&wr_ready, latch wr_rs/wr_data, set nibble index 0, load RS_lcd and data_lcd (full byte, or high nibble in 4-bit mode) -> SETUP.
- SETUP (SETUP_CYC cycles) -> E_HIGH: E_lcd=1 for E_CYC cycles -> HOLD: E_lcd=0, HOLD_CYC cycles.
- After HOLD: 4-bit mode with nibble index 0 -> load low nibble, index 1, -> SETUP; otherwise -> WAIT_EXEC.
- WAIT_EXEC lasts LONG_CYC if latched rs=0 and byte matches 8'b0000001x or 8'h01, else EXEC_CYC; then -> IDLE with done=1 that cycle.
- busy = (state != IDLE). Inputs ignored while busy; wr_valid may stay high with no effect until wr_ready.
- RS_lcd/data_lcd change only on entry to SETUP; stable through SETUP, E_HIGH, HOLD and WAIT_EXEC.
- Reset (asynchronous, any state): state IDLE, all outputs 0, wr_ready=1 after release; an in-progress transfer is dropped, no done.

## Timing
- Each timed state lasts exactly its parameter in cycles: one down-counter loaded with N-1 on state entry; transition when zero.
- 8-bit latency, accept edge to done cycle: SETUP_CYC+E_CYC+HOLD_CYC+WAIT cycles; wr_ready rises in the done cycle; a new request may be accepted that cycle.
- 4-bit: 2×(SETUP_CYC+E_CYC+HOLD_CYC)+WAIT.
- Counter width: $clog2(max of all parameters)+1.
- All outputs registered; no combinational path from wr_* to LCD pins.

## Structure
- Package lcd_pkg: state enum, CMD_CLEAR=8'h01, CMD_HOME=8'h02, long-wait match function.
- One sub-module, lcd_cycle_timer: loadable down-counter with zero flag, parametrised width; shared by all timed states.

## Test plan
Use SETUP=2, E=3, HOLD=1, EXEC=10, LONG=50 for all scenarios.
- 8-bit data write rs=1, 0x8C -> RS_lcd=1, data_lcd=0x8C for 2 cycles before E; E high exactly 3 cycles; done 16 cycles after accept.
- Command 0x01 rs=0 -> wait 50; done 56 cycles after accept. Same for 0x03. Data 0x01 with rs=1 -> 16 cycles.
- BUS_4BIT=1, data 0xA5 -> two E pulses, data_lcd 0xA0 then 0x50; done 22 cycles after accept.
- wr_valid held high during busy with changing wr_data -> second byte accepted only in the done cycle; the first byte is unaffected.
- reset_n low during E_HIGH -> E_lcd, RS_lcd and data_lcd 0 immediately, no done; wr_ready=1 after release.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types, command codes and helpers for the LCD write engine.
//   lcd_state_e    - write engine FSM states
//   CMD_CLEAR/HOME - instruction codes that need the long execution wait
//   is_long_wait() - true when a latched instruction needs the long wait
//   max2()         - constant-friendly maximum used to size the cycle timer
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_E_HIGH    = 3'd2,
        ST_HOLD      = 3'd3,
        ST_WAIT_EXEC = 3'd4
    } lcd_state_e;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    // Clear (0x01) and home (0x02/0x03, bit 0 is don't-care) are the slow
    // instructions; data writes never take the long wait.
    function automatic logic is_long_wait(input logic rs, input logic [7:0] data);
        return (rs == 1'b0) &&
               ((data[7:1] == CMD_HOME[7:1]) || (data == CMD_CLEAR));
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_cycle_timer.sv
// lcd_cycle_timer: loadable down-counter shared by every timed engine state.
//   clk, rst_n - clock, asynchronous active-low reset
//   load       - load load_val this cycle (takes priority over counting)
//   load_val   - value to load, N-1 for an N-cycle interval
//   zero       - counter currently holds zero (interval elapsed)
module lcd_cycle_timer
    import lcd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count_r;

    // Load on state entry, otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_val;
        end else if (count_r != '0) begin
            count_r <= count_r - WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == '0);

endmodule

// File: rtl/lcd_write_engine.sv
// lcd_write_engine: accepts instruction/data bytes over valid/ready and
// drives an HD44780-style bus with programmable setup, enable, hold and
// execution-wait timing, in 8-bit or 4-bit (high nibble first) mode.
//   clk, reset_n        - clock, asynchronous active-low reset
//   wr_valid/wr_ready   - request handshake; wr_rs selects data(1)/instr(0)
//   wr_data             - byte to write
//   busy                - transfer or execution wait in progress
//   done                - one-cycle pulse when a transfer's wait completes
//   RW_lcd, RS_lcd, E_lcd, data_lcd - registered LCD pins
module lcd_write_engine
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int E_CYC     = 12,
    parameter int HOLD_CYC  = 1,
    parameter int EXEC_CYC  = 1850,
    parameter int LONG_CYC  = 76000,
    parameter int BUS_4BIT  = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       RW_lcd,
    output logic       RS_lcd,
    output logic       E_lcd,
    output logic [7:0] data_lcd
);

    localparam int MAX_CYC = max2(max2(max2(SETUP_CYC, E_CYC), max2(HOLD_CYC, EXEC_CYC)), LONG_CYC);
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] E_LD     = CNT_W'(E_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_CYC - 1);
    localparam logic             IS_4BIT  = (BUS_4BIT != 0);

    lcd_state_e       state_r;
    logic [3:0]       low_nib_r;
    logic             nib_r;
    logic             long_r;
    logic             rs_lcd_r;
    logic             e_lcd_r;
    logic [7:0]       data_lcd_r;
    logic             done_r;
    logic             busy_r;
    logic             ready_r;

    logic             accept_s;
    logic             zero_s;
    logic             load_s;
    logic [CNT_W-1:0] load_val_s;

    assign accept_s = (state_r == ST_IDLE) && wr_valid && ready_r;

    // Timer reload for whichever timed state is entered next.
    always_comb begin
        load_s     = 1'b0;
        load_val_s = '0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    load_s     = 1'b1;
                    load_val_s = SETUP_LD;
                end else begin
                    load_s     = 1'b0;
                end
            end
            ST_SETUP: begin
                if (zero_s) begin
                    load_s     = 1'b1;
                    load_val_s = E_LD;
                end else begin
                    load_s     = 1'b0;
                end
            end
            ST_E_HIGH: begin
                if (zero_s) begin
                    load_s     = 1'b1;
                    load_val_s = HOLD_LD;
                end else begin
                    load_s     = 1'b0;
                end
            end
            ST_HOLD: begin
                if (zero_s && IS_4BIT && !nib_r) begin
                    load_s     = 1'b1;
                    load_val_s = SETUP_LD;
                end else if (zero_s) begin
                    load_s     = 1'b1;
                    load_val_s = long_r ? LONG_LD : EXEC_LD;
                end else begin
                    load_s     = 1'b0;
                end
            end
            default: begin
                load_s     = 1'b0;
                load_val_s = '0;
            end
        endcase
    end

    lcd_cycle_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (reset_n),
        .load     (load_s),
        .load_val (load_val_s),
        .zero     (zero_s)
    );

    // Transfer FSM; all pins and status flags are registered here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            low_nib_r  <= 4'h0;
            nib_r      <= 1'b0;
            long_r     <= 1'b0;
            rs_lcd_r   <= 1'b0;
            e_lcd_r    <= 1'b0;
            data_lcd_r <= 8'h00;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            ready_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r    <= ST_SETUP;
                        low_nib_r  <= wr_data[3:0];
                        nib_r      <= 1'b0;
                        long_r     <= is_long_wait(wr_rs, wr_data);
                        rs_lcd_r   <= wr_rs;
                        data_lcd_r <= IS_4BIT ? {wr_data[7:4], 4'h0} : wr_data;
                        busy_r     <= 1'b1;
                        ready_r    <= 1'b0;
                    end else begin
                        busy_r     <= 1'b0;
                        ready_r    <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (zero_s) begin
                        state_r <= ST_E_HIGH;
                        e_lcd_r <= 1'b1;
                    end
                end
                ST_E_HIGH: begin
                    if (zero_s) begin
                        state_r <= ST_HOLD;
                        e_lcd_r <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (zero_s && IS_4BIT && !nib_r) begin
                        // Second pass of a 4-bit transfer carries the low nibble.
                        state_r    <= ST_SETUP;
                        nib_r      <= 1'b1;
                        data_lcd_r <= {low_nib_r, 4'h0};
                    end else if (zero_s) begin
                        state_r <= ST_WAIT_EXEC;
                    end
                end
                ST_WAIT_EXEC: begin
                    if (zero_s) begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    e_lcd_r <= 1'b0;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign wr_ready = ready_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign RW_lcd   = 1'b0;
    assign RS_lcd   = rs_lcd_r;
    assign E_lcd    = e_lcd_r;
    assign data_lcd = data_lcd_r;

endmodule

// File: tb/tb_lcd_write_engine.sv
// Self-checking bench for lcd_write_engine: one 8-bit and one 4-bit instance
// with short timing (setup 2, enable 3, hold 1, exec 10, long 50).
module tb_lcd_write_engine;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sel;

    logic       v8, rs8, r8, b8, dn8, rw8, rsl8, e8;
    logic [7:0] d8, dl8;
    logic       v4, rs4, r4, b4, dn4, rw4, rsl4, e4;
    logic [7:0] d4, dl4;

    logic       m_ready, m_busy, m_done, m_rw, m_rs, m_e;
    logic [7:0] m_data;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       sel;
        logic       rs;
        logic [7:0] data;
        int         lat;
    } vec_t;

    vec_t vecs[12];
    vec_t sb_q[$];

    always #5 clk = ~clk;

    lcd_write_engine #(
        .SETUP_CYC(2), .E_CYC(3), .HOLD_CYC(1), .EXEC_CYC(10), .LONG_CYC(50), .BUS_4BIT(0)
    ) dut8 (
        .clk(clk), .reset_n(reset_n), .wr_valid(v8), .wr_ready(r8), .wr_rs(rs8),
        .wr_data(d8), .busy(b8), .done(dn8), .RW_lcd(rw8), .RS_lcd(rsl8),
        .E_lcd(e8), .data_lcd(dl8)
    );

    lcd_write_engine #(
        .SETUP_CYC(2), .E_CYC(3), .HOLD_CYC(1), .EXEC_CYC(10), .LONG_CYC(50), .BUS_4BIT(1)
    ) dut4 (
        .clk(clk), .reset_n(reset_n), .wr_valid(v4), .wr_ready(r4), .wr_rs(rs4),
        .wr_data(d4), .busy(b4), .done(dn4), .RW_lcd(rw4), .RS_lcd(rsl4),
        .E_lcd(e4), .data_lcd(dl4)
    );

    assign m_ready = sel ? r4   : r8;
    assign m_busy  = sel ? b4   : b8;
    assign m_done  = sel ? dn4  : dn8;
    assign m_rw    = sel ? rw4  : rw8;
    assign m_rs    = sel ? rsl4 : rsl8;
    assign m_e     = sel ? e4   : e8;
    assign m_data  = sel ? dl4  : dl8;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (m_ready) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Drive one request, push its expectation, then observe the bus until done.
    task automatic run_vec(input vec_t v);
        bit         ok;
        vec_t       e;
        int         lat, e_cnt, pulses, setup_cnt;
        bit         prev_e, busy_bad, rs_bad;
        logic [7:0] cap0, cap1, exp0, exp1;
        lat = -1; e_cnt = 0; pulses = 0; setup_cnt = 0;
        prev_e = 1'b0; busy_bad = 1'b0; rs_bad = 1'b0;
        cap0 = 8'h00; cap1 = 8'h00;
        sel = v.sel;
        wait_ready(ok);
        if (!ok) begin
            check("ready_timeout", 32'd0, 32'd1);
            return;
        end
        if (v.sel) begin v4 = 1'b1; rs4 = v.rs; d4 = v.data; end
        else       begin v8 = 1'b1; rs8 = v.rs; d8 = v.data; end
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        v4 = 1'b0;
        v8 = 1'b0;
        exp0 = v.sel ? {v.data[7:4], 4'h0} : v.data;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (m_done) begin
                lat = n;
                break;
            end
            if (!m_busy || m_ready) busy_bad = 1'b1;
            if (m_rs !== v.rs || m_rw !== 1'b0) rs_bad = 1'b1;
            if (m_e) begin
                e_cnt++;
                if (!prev_e) begin
                    if (pulses == 0) cap0 = m_data;
                    else             cap1 = m_data;
                    pulses++;
                end
            end else if (pulses == 0 && m_data === exp0) begin
                setup_cnt++;
            end
            prev_e = m_e;
        end
        e = sb_q.pop_front();
        exp1 = {e.data[3:0], 4'h0};
        check("latency",      32'(lat),       32'(e.lat));
        check("e_pulses",     32'(pulses),    e.sel ? 32'd2 : 32'd1);
        check("e_high_cyc",   32'(e_cnt),     e.sel ? 32'd6 : 32'd3);
        check("setup_cyc",    32'(setup_cnt), 32'd2);
        check("first_word",   32'(cap0),      32'(e.sel ? {e.data[7:4], 4'h0} : e.data));
        if (e.sel) check("second_word", 32'(cap1), 32'(exp1));
        check("busy_ready_during", 32'(busy_bad), 32'd0);
        check("rs_rw_stable",      32'(rs_bad),   32'd0);
        check("ready_at_done",     32'(m_ready),  32'd1);
        @(negedge clk);
        check("done_one_cycle",    32'(m_done),   32'd0);
    endtask

    initial begin
        bit         ok;
        bit         bad, seen;
        int         lat;
        reset_n = 1'b0;
        sel = 1'b0;
        v8 = 1'b0; rs8 = 1'b0; d8 = 8'h00;
        v4 = 1'b0; rs4 = 1'b0; d4 = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_e8",    32'(e8),   32'd0);
        check("rst_rs8",   32'(rsl8), 32'd0);
        check("rst_data8", 32'(dl8),  32'd0);
        check("rst_done8", 32'(dn8),  32'd0);
        check("rst_busy8", 32'(b8),   32'd0);
        check("rst_rw8",   32'(rw8),  32'd0);
        check("rst_data4", 32'(dl4),  32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_ready8", 32'(r8), 32'd1);
        check("post_rst_ready4", 32'(r4), 32'd1);
        check("post_rst_busy8",  32'(b8), 32'd0);

        // Vector table: {4-bit instance, rs, byte, accept-to-done cycles}
        vecs[0]  = '{1'b0, 1'b1, 8'h8C, 16};
        vecs[1]  = '{1'b0, 1'b0, 8'h01, 56};
        vecs[2]  = '{1'b0, 1'b0, 8'h03, 56};
        vecs[3]  = '{1'b0, 1'b0, 8'h02, 56};
        vecs[4]  = '{1'b0, 1'b1, 8'h01, 16};
        vecs[5]  = '{1'b0, 1'b0, 8'h04, 16};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 16};
        vecs[7]  = '{1'b0, 1'b1, 8'h03, 16};
        vecs[8]  = '{1'b1, 1'b1, 8'hA5, 22};
        vecs[9]  = '{1'b1, 1'b0, 8'h01, 62};
        vecs[10] = '{1'b1, 1'b0, 8'h28, 22};
        vecs[11] = '{1'b1, 1'b0, 8'h02, 62};
        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i]);
        end

        // wr_valid held through a busy transfer with changing wr_data
        sel = 1'b0;
        wait_ready(ok);
        check("b2b_ready", 32'(ok), 32'd1);
        v8 = 1'b1; rs8 = 1'b1; d8 = 8'h11;
        @(posedge clk);
        #1;
        bad = 1'b0;
        lat = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (dn8) begin
                lat = n;
                break;
            end
            if (dl8 !== 8'h11 || rsl8 !== 1'b1) bad = 1'b1;
            d8  = 8'h20 + 8'(n);
            rs8 = ~rs8;
        end
        check("b2b_first_lat",    32'(lat), 32'd16);
        check("b2b_first_stable", 32'(bad), 32'd0);
        check("b2b_done_data",    32'(dl8), 32'h11);
        check("b2b_done_ready",   32'(r8),  32'd1);
        d8 = 8'h77; rs8 = 1'b0;
        @(negedge clk);
        v8 = 1'b0;
        check("b2b_second_busy", 32'(b8),   32'd1);
        check("b2b_second_data", 32'(dl8),  32'h77);
        check("b2b_second_rs",   32'(rsl8), 32'd0);
        lat = -1;
        for (int n = 1; n < 100; n++) begin
            @(negedge clk);
            if (dn8) begin
                lat = n;
                break;
            end
        end
        check("b2b_second_lat", 32'(lat), 32'd16);

        // Reset asserted while E is high
        sel = 1'b0;
        wait_ready(ok);
        v8 = 1'b1; rs8 = 1'b1; d8 = 8'hFF;
        @(posedge clk);
        #1;
        v8 = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_e_high", 32'(e8), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_e",    32'(e8),   32'd0);
        check("mid_rst_rs",   32'(rsl8), 32'd0);
        check("mid_rst_data", 32'(dl8),  32'd0);
        check("mid_rst_busy", 32'(b8),   32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (dn8) seen = 1'b1;
        end
        check("mid_rst_no_done", 32'(seen), 32'd0);
        check("mid_rst_ready",   32'(r8),   32'd1);
        run_vec('{1'b0, 1'b1, 8'h5A, 16});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
